mem_stage: RTL and testbench

Memory-access stage of the five-stage MIPS pipeline. It sits after the EX/MEM register and owns the byte-addressable data memory. It performs word, halfword and byte loads and stores with sign or zero extension, and drives the MEM/WB pipeline register consumed by write-back and forwarding. Advancement is gated by the debugger step strobe. An optional debug read port lets the debug unit inspect data memory while the pipeline is halted.

---
 rtl/mem_stage.sv | 169 ++++++++++++++++
 tb/tb_mem_stage.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
// MIPS memory-access stage: byte-addressable data memory, sized/extended loads and stores, MEM/WB register.
// Optional debug read port enabled by defining MEM_STAGE_DBG_PORT_EN.
module mem_stage #(
    parameter int NB_DATA = 32,
    parameter int NB_ADDR = 8
) (
    input  logic               clk,
    input  logic               i_reset,
    input  logic               i_step,
    input  logic               i_mem2reg,
    input  logic               i_memWrite,
    input  logic               i_regWrite,
    input  logic [1:0]         i_width,
    input  logic               i_sign_flag,
    input  logic [4:0]         i_write_reg,
    input  logic [NB_DATA-1:0] i_result,
    input  logic [NB_DATA-1:0] i_data4Mem,
    input  logic               i_dbg_rd_en,
    input  logic [NB_ADDR-1:0] i_dbg_addr,
    output logic               o_mem2reg,
    output logic               o_regWrite,
    output logic [4:0]         o_write_reg,
    output logic [NB_DATA-1:0] o_read_data,
    output logic [NB_DATA-1:0] o_result,
    output logic               o_misalign,
    output logic [NB_DATA-1:0] o_dbg_data,
    output logic               o_dbg_valid
);
    localparam int DEPTH = 1 << NB_ADDR;

    logic [NB_DATA-1:0] mem_q [DEPTH];

    logic [NB_ADDR-1:0] word_idx;
    logic [1:0]         offset;
    logic               misaligned;
    logic [NB_DATA-1:0] rd_word;
    logic [NB_DATA-1:0] lane_shift;
    logic [15:0]        half_sel;
    logic [NB_DATA-1:0] load_data;
    logic [NB_DATA-1:0] wr_data;
    logic [3:0]         wr_be;
    logic               store_en;

    logic               mem2reg_q, mem2reg_d;
    logic               regwrite_q, regwrite_d;
    logic [4:0]         write_reg_q, write_reg_d;
    logic [NB_DATA-1:0] read_data_q, read_data_d;
    logic [NB_DATA-1:0] result_q, result_d;
    logic               misalign_q, misalign_d;

    // Upper address bits are deliberately dropped so addresses wrap.
    logic unused_addr_bits;
    assign unused_addr_bits = &{1'b0, i_result[NB_DATA-1:NB_ADDR+2]};

    assign word_idx = i_result[NB_ADDR+1:2];
    assign offset   = i_result[1:0];

    always_comb begin
        misaligned = 1'b0;
        load_data  = '0;
        wr_data    = i_data4Mem;
        wr_be      = 4'b1111;
        rd_word    = mem_q[word_idx];
        lane_shift = rd_word >> {offset, 3'b000};
        half_sel   = offset[1] ? rd_word[31:16] : rd_word[15:0];
        case (i_width)
            2'b00: begin
                load_data = i_sign_flag ? {{24{lane_shift[7]}}, lane_shift[7:0]}
                                        : {24'b0, lane_shift[7:0]};
                wr_data   = {4{i_data4Mem[7:0]}};
                wr_be     = 4'b0001 << offset;
            end
            2'b01: begin
                misaligned = offset[0];
                load_data  = i_sign_flag ? {{16{half_sel[15]}}, half_sel}
                                         : {16'b0, half_sel};
                wr_data    = {2{i_data4Mem[15:0]}};
                wr_be      = offset[1] ? 4'b1100 : 4'b0011;
            end
            default: begin
                misaligned = (offset != 2'b00);
                load_data  = rd_word;
            end
        endcase
    end

    // Reset low at the edge blocks the store even though memory itself is not reset.
    assign store_en = i_reset & i_step & i_memWrite & ~misaligned;

    always_ff @(posedge clk) begin
        if (store_en) begin
            for (int k = 0; k < 4; k++) begin
                if (wr_be[k]) mem_q[word_idx][8*k +: 8] <= wr_data[8*k +: 8];
            end
        end
    end

    always_comb begin
        mem2reg_d   = mem2reg_q;
        regwrite_d  = regwrite_q;
        write_reg_d = write_reg_q;
        read_data_d = read_data_q;
        result_d    = result_q;
        misalign_d  = misalign_q;
        if (i_step) begin
            mem2reg_d   = i_mem2reg;
            regwrite_d  = i_regWrite & ~(i_mem2reg & misaligned);
            write_reg_d = i_write_reg;
            read_data_d = (i_mem2reg && !misaligned) ? load_data : '0;
            result_d    = i_result;
            misalign_d  = misalign_q | ((i_mem2reg | i_memWrite) & misaligned);
        end
    end

    always_ff @(posedge clk or negedge i_reset) begin
        if (!i_reset) begin
            mem2reg_q   <= 1'b0;
            regwrite_q  <= 1'b0;
            write_reg_q <= '0;
            read_data_q <= '0;
            result_q    <= '0;
            misalign_q  <= 1'b0;
        end else begin
            mem2reg_q   <= mem2reg_d;
            regwrite_q  <= regwrite_d;
            write_reg_q <= write_reg_d;
            read_data_q <= read_data_d;
            result_q    <= result_d;
            misalign_q  <= misalign_d;
        end
    end

    assign o_mem2reg   = mem2reg_q;
    assign o_regWrite  = regwrite_q;
    assign o_write_reg = write_reg_q;
    assign o_read_data = read_data_q;
    assign o_result    = result_q;
    assign o_misalign  = misalign_q;

`ifdef MEM_STAGE_DBG_PORT_EN
    logic [NB_DATA-1:0] dbg_data_q, dbg_data_d;
    logic               dbg_valid_q, dbg_valid_d;

    // Registered read samples the pre-store word when a store hits the same edge.
    always_comb begin
        dbg_data_d  = i_dbg_rd_en ? mem_q[i_dbg_addr] : dbg_data_q;
        dbg_valid_d = i_dbg_rd_en;
    end

    always_ff @(posedge clk or negedge i_reset) begin
        if (!i_reset) begin
            dbg_data_q  <= '0;
            dbg_valid_q <= 1'b0;
        end else begin
            dbg_data_q  <= dbg_data_d;
            dbg_valid_q <= dbg_valid_d;
        end
    end

    assign o_dbg_data  = dbg_data_q;
    assign o_dbg_valid = dbg_valid_q;
`else
    logic unused_dbg;
    assign unused_dbg  = &{1'b0, i_dbg_rd_en, i_dbg_addr};
    assign o_dbg_data  = '0;
    assign o_dbg_valid = 1'b0;
`endif

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed scenarios plus randomized traffic against a byte-array model.
// Debug-port expectations follow MEM_STAGE_DBG_PORT_EN.
module tb_mem_stage;
    logic        clk = 1'b0;
    logic        i_reset, i_step, i_mem2reg, i_memWrite, i_regWrite, i_sign_flag;
    logic [1:0]  i_width;
    logic [4:0]  i_write_reg;
    logic [31:0] i_result, i_data4Mem;
    logic        i_dbg_rd_en;
    logic [7:0]  i_dbg_addr;
    logic        o_mem2reg, o_regWrite, o_misalign, o_dbg_valid;
    logic [4:0]  o_write_reg;
    logic [31:0] o_read_data, o_result, o_dbg_data;

    always #5 clk = ~clk;

    mem_stage dut (
        .clk(clk), .i_reset(i_reset), .i_step(i_step), .i_mem2reg(i_mem2reg),
        .i_memWrite(i_memWrite), .i_regWrite(i_regWrite), .i_width(i_width),
        .i_sign_flag(i_sign_flag), .i_write_reg(i_write_reg), .i_result(i_result),
        .i_data4Mem(i_data4Mem), .i_dbg_rd_en(i_dbg_rd_en), .i_dbg_addr(i_dbg_addr),
        .o_mem2reg(o_mem2reg), .o_regWrite(o_regWrite), .o_write_reg(o_write_reg),
        .o_read_data(o_read_data), .o_result(o_result), .o_misalign(o_misalign),
        .o_dbg_data(o_dbg_data), .o_dbg_valid(o_dbg_valid)
    );

    // Reference model: memory as a flat little-endian byte array.
    logic [7:0]  mb [1024];
    logic        exp_mem2reg, exp_regwrite, exp_mis, exp_dbg_valid;
    logic [4:0]  exp_wr;
    logic [31:0] exp_read, exp_result, exp_dbg_data;
    int          n_checks = 0;
    int          n_fail = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model_word(input logic [9:0] ba);
        logic [9:0] b0;
        b0 = {ba[9:2], 2'b00};
        return {mb[b0 + 10'd3], mb[b0 + 10'd2], mb[b0 + 10'd1], mb[b0]};
    endfunction

    task automatic model_reset();
        exp_mem2reg = 0; exp_regwrite = 0; exp_wr = 0; exp_read = 0;
        exp_result = 0; exp_mis = 0; exp_dbg_valid = 0; exp_dbg_data = 0;
    endtask

    task automatic model_edge();
        logic [9:0]  ba;
        logic        mis;
        logic [31:0] ld;
        logic [15:0] h;
        if (!i_reset) begin
            model_reset();
            return;
        end
`ifdef MEM_STAGE_DBG_PORT_EN
        if (i_dbg_rd_en) exp_dbg_data = model_word({i_dbg_addr, 2'b00});
        exp_dbg_valid = i_dbg_rd_en;
`endif
        if (!i_step) return;
        ba  = i_result[9:0];
        mis = (i_width == 2'b01 && ba[0]) || (i_width[1] && ba[1:0] != 2'b00);
        h   = {mb[ba + 10'd1], mb[ba]};
        case (i_width)
            2'b00:   ld = i_sign_flag ? 32'($signed(mb[ba])) : {24'b0, mb[ba]};
            2'b01:   ld = i_sign_flag ? 32'($signed(h)) : {16'b0, h};
            default: ld = model_word(ba);
        endcase
        exp_mem2reg  = i_mem2reg;
        exp_regwrite = i_regWrite && !(i_mem2reg && mis);
        exp_read     = (i_mem2reg && !mis) ? ld : 32'd0;
        exp_result   = i_result;
        exp_wr       = i_write_reg;
        if ((i_mem2reg || i_memWrite) && mis) exp_mis = 1;
        if (i_memWrite && !mis) begin
            mb[ba] = i_data4Mem[7:0];
            if (i_width != 2'b00) mb[ba + 10'd1] = i_data4Mem[15:8];
            if (i_width[1]) begin
                mb[ba + 10'd2] = i_data4Mem[23:16];
                mb[ba + 10'd3] = i_data4Mem[31:24];
            end
        end
    endtask

    task automatic check_outputs();
        check("mem2reg", o_mem2reg, exp_mem2reg);
        check("regwrite", o_regWrite, exp_regwrite);
        check("write_reg", o_write_reg, exp_wr);
        check("read_data", o_read_data, exp_read);
        check("result", o_result, exp_result);
        check("misalign", o_misalign, exp_mis);
        check("dbg_data", o_dbg_data, exp_dbg_data);
        check("dbg_valid", o_dbg_valid, exp_dbg_valid);
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_outputs();
    endtask

    task automatic op(input logic m2r, input logic mw, input logic rw, input logic [1:0] w,
                      input logic sg, input logic [31:0] addr, input logic [31:0] data);
        i_step = 1; i_mem2reg = m2r; i_memWrite = mw; i_regWrite = rw; i_width = w;
        i_sign_flag = sg; i_write_reg = addr[4:0] ^ 5'd7; i_result = addr; i_data4Mem = data;
        i_dbg_rd_en = 0; i_dbg_addr = 0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] held;
        logic [31:0] r;
        for (int i = 0; i < 1024; i++) mb[i] = 8'h00;
        model_reset();
        i_reset = 0;
        op(0, 0, 0, 2'b00, 0, 0, 0);
        repeat (2) @(negedge clk);
        check_outputs();
        check("reset_misalign", o_misalign, 0);
        i_reset = 1;

        for (int w = 0; w < 256; w++) begin
            op(0, 1, 0, 2'b10, 0, w * 4, 0);
            cycle();
        end

        op(0, 1, 0, 2'b10, 0, 32'h10, 32'hDEADBEEF); cycle();
        op(1, 0, 1, 2'b10, 1, 32'h10, 0); cycle();
        check("rt_word", o_read_data, 32'hDEADBEEF);
        check("rt_regwrite", o_regWrite, 1);

        op(0, 1, 0, 2'b00, 0, 32'h11, 32'h0000_0080); cycle();
        op(1, 0, 1, 2'b10, 1, 32'h10, 0); cycle();
        check("lane_word", o_read_data, 32'hDEAD80EF);
        op(1, 0, 1, 2'b00, 1, 32'h11, 0); cycle();
        check("byte_signed", o_read_data, 32'hFFFFFF80);
        op(1, 0, 1, 2'b00, 0, 32'h11, 0); cycle();
        check("byte_unsigned", o_read_data, 32'h00000080);
        op(1, 0, 1, 2'b01, 1, 32'h12, 0); cycle();
        check("half_signed", o_read_data, 32'hFFFFDEAD);

        op(0, 1, 0, 2'b10, 0, 32'h13, 32'h12345678); cycle();
        check("mis_store_flag", o_misalign, 1);
        op(1, 0, 1, 2'b10, 1, 32'h10, 0); cycle();
        check("mis_store_nochange", o_read_data, 32'hDEAD80EF);
        op(1, 0, 1, 2'b01, 1, 32'h11, 0); cycle();
        check("mis_load_data", o_read_data, 0);
        check("mis_load_regwrite", o_regWrite, 0);

        op(1, 0, 1, 2'b10, 0, 32'h10, 0); cycle();
        held = o_read_data;
        for (int i = 0; i < 5; i++) begin
            op($urandom_range(0, 1), 1, $urandom_range(0, 1), 2'b10, 0, 32'h10, $urandom);
            i_step = 0;
            cycle();
            check("hold_read", o_read_data, held);
        end
        op(1, 0, 1, 2'b10, 0, 32'h10, 0); cycle();
        check("hold_mem", o_read_data, 32'hDEAD80EF);

        op(0, 0, 0, 2'b00, 0, 0, 0);
        i_step = 0; i_dbg_rd_en = 1; i_dbg_addr = 8'd4;
        cycle();
`ifdef MEM_STAGE_DBG_PORT_EN
        check("dbg_read", o_dbg_data, 32'hDEAD80EF);
        check("dbg_pulse", o_dbg_valid, 1);
`else
        check("dbg_off_data", o_dbg_data, 0);
        check("dbg_off_valid", o_dbg_valid, 0);
`endif
        i_dbg_rd_en = 0; cycle();
        op(0, 1, 0, 2'b10, 0, 32'h10, 32'h11223344);
        i_dbg_rd_en = 1; i_dbg_addr = 8'd4;
        cycle();
`ifdef MEM_STAGE_DBG_PORT_EN
        check("dbg_rbw", o_dbg_data, 32'hDEAD80EF);
`endif
        op(1, 0, 1, 2'b10, 0, 32'h10, 0); cycle();
        check("after_rbw_store", o_read_data, 32'h11223344);

        for (int i = 0; i < 400; i++) begin
            r = $urandom;
            r[9:0] = 10'($urandom_range(0, 63));
            op($urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1),
               2'($urandom_range(0, 3)), $urandom_range(0, 1), r, $urandom);
            i_write_reg = 5'($urandom_range(0, 31));
            i_step = ($urandom_range(0, 3) != 0);
            i_dbg_rd_en = $urandom_range(0, 1);
            i_dbg_addr = 8'($urandom_range(0, 15));
            cycle();
        end

        op(0, 1, 0, 2'b10, 0, 32'h20, 32'hAABBCCDD); cycle();
        op(0, 1, 1, 2'b10, 0, 32'h20, 32'h55667788);
        #2;
        i_reset = 0;
        model_reset();
        #1;
        check("rst_async_result", o_result, 0);
        check("rst_async_misalign", o_misalign, 0);
        check_outputs();
        cycle();
        i_reset = 1;
        op(1, 0, 1, 2'b10, 0, 32'h20, 0); cycle();
        check("rst_mem_kept", o_read_data, 32'hAABBCCDD);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
